counter_share_ctrl: RTL and testbench

//  Round-robin controller that time-shares one up-counter (clk/rst/enb/count) among NREQ requesters.

---
 rtl/counter_share_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/counter_share_ctrl.sv | 129 ++++++++++++
 tb/tb_counter_share_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_share_pkg.sv
// Shared types and helpers for the counter time-share controller.
package counter_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } cs_state_t;

    localparam int MAX_REQ = 16;

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter
    import counter_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_onehot_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] pos;
        gnt_onehot_o = '0;
        found        = 1'b0;
        pos          = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IDX_W'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[pos]) begin
                gnt_onehot_o[pos] = 1'b1;
                found             = 1'b1;
            end
        end
    end

    assign gnt_idx_o = IDX_W'(onehot_to_idx(MAX_REQ'(gnt_onehot_o)));

endmodule

// File: rtl/counter_share_ctrl.sv
// Round-robin controller time-sharing one free-running up-counter among NREQ requesters.
// Progress is measured as (cnt_val - base) mod 2^CNT_W, so the counter is never cleared.
module counter_share_ctrl
    import counter_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  aborted,
    output logic                  busy,
    output logic                  cnt_enb,
    input  logic [CNT_W-1:0]      cnt_val
);

    localparam int IDX_W = $clog2(NREQ);

    cs_state_t        state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] base_q, base_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             aborted_q, aborted_d;

    logic [NREQ-1:0]  arb_onehot;
    logic [IDX_W-1:0] arb_idx;
    logic [CNT_W-1:0] len_arr [NREQ];
    logic [CNT_W-1:0] elapsed;

    for (genvar i = 0; i < NREQ; i++) begin : g_len
        assign len_arr[i] = len[i*CNT_W +: CNT_W];
    end

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .gnt_onehot_o (arb_onehot),
        .gnt_idx_o    (arb_idx)
    );

    assign elapsed = cnt_val - base_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        len_d     = len_q;
        base_d    = base_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = arb_onehot;
                    idx_d   = arb_idx;
                    len_d   = len_arr[arb_idx];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Counter is held (enb low) here, so this is the job's zero point.
                base_d = cnt_val;
                if (len_q == '0) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The final tick wins over a request dropped in the same cycle.
                if (elapsed == len_q - CNT_W'(1)) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = DONE;
                end else if (!req[idx_q]) begin
                    done_d    = gnt_q;
                    aborted_d = 1'b1;
                    gnt_d     = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                ptr_d   = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            base_q    <= base_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign busy    = (state_q != IDLE);
    assign cnt_enb = (state_q == RUN);

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Bench for counter_share_ctrl: job-timeline reference model, per-cycle compare, directed scenarios.
module tb_counter_share_ctrl;

    localparam int NREQ  = 4;
    localparam int CNT_W = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  aborted;
    logic                  busy;
    logic                  cnt_enb;
    logic [CNT_W-1:0]      count;

    logic                  preset_en;
    logic [CNT_W-1:0]      preset_val;
    int                    cyc = 0;
    int                    enb_total = 0;
    int                    n_checks = 0;
    int                    n_fail = 0;

    counter_share_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .done    (done),
        .aborted (aborted),
        .busy    (busy),
        .cnt_enb (cnt_enb),
        .cnt_val (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared up-counter; never reset, optionally preset by the bench while idle.
    always @(posedge clk) begin
        if (preset_en)    count <= preset_val;
        else if (cnt_enb) count <= count + 8'd1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_enb) enb_total <= enb_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Reference model. A job is tracked as t = cycles since its grant edge (t=1 is the
    // first granted cycle) and ticks = counter increments it is entitled to:
    //   gnt for t in [1, 1+ticks], enb for t in [2, 1+ticks], done at t = 2+ticks.
    // A request dropped in an enb cycle t (not the last) shortens ticks to t-1.
    int m_t = 0, m_ticks = 0, m_idx = 0, m_ptr = 0;
    bit m_job = 1'b0, m_ab = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int t_n, ticks_n, idx_n, ptr_n;
        bit job_n, ab_n, found;
        if (rst) begin
            m_t <= 0; m_ticks <= 0; m_idx <= 0; m_ptr <= 0; m_job <= 1'b0; m_ab <= 1'b0;
        end else begin
            t_n = m_t; ticks_n = m_ticks; idx_n = m_idx; ptr_n = m_ptr; job_n = m_job; ab_n = m_ab;
            if (job_n) begin
                if (t_n >= 2 && t_n < 1 + ticks_n && !req[idx_n]) begin
                    ticks_n = t_n - 1;
                    ab_n    = 1'b1;
                end
                t_n++;
                if (t_n == 3 + ticks_n) begin
                    job_n = 1'b0;
                    ptr_n = (idx_n + 1) % NREQ;
                end
            end else if (req != '0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req[(ptr_n + k) % NREQ]) begin
                        idx_n = (ptr_n + k) % NREQ;
                        found = 1'b1;
                    end
                end
                job_n   = 1'b1;
                t_n     = 1;
                ticks_n = int'(len[idx_n*CNT_W +: CNT_W]);
                ab_n    = 1'b0;
            end
            m_t <= t_n; m_ticks <= ticks_n; m_idx <= idx_n; m_ptr <= ptr_n; m_job <= job_n; m_ab <= ab_n;
        end
    end

    always @(negedge clk) begin : compare
        logic [NREQ-1:0] oh, e_gnt, e_done;
        logic            e_enb, e_ab;
        oh = '0;
        if (m_job) oh[m_idx] = 1'b1;
        e_gnt  = (m_job && m_t <= 1 + m_ticks) ? oh : '0;
        e_enb  = m_job && m_t >= 2 && m_t <= 1 + m_ticks;
        e_done = (m_job && m_t == 2 + m_ticks) ? oh : '0;
        e_ab   = m_job && m_t == 2 + m_ticks && m_ab;
        check("cmp_gnt", 32'(gnt), 32'(e_gnt));
        check("cmp_cnt_enb", 32'(cnt_enb), 32'(e_enb));
        check("cmp_done", 32'(done), 32'(e_done));
        check("cmp_aborted", 32'(aborted), 32'(e_ab));
        check("cmp_busy", 32'(busy), 32'(m_job));
        check("cmp_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end

    task automatic wait_done(input int budget, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < budget) begin
            @(negedge clk);
            if (|done) ok = 1'b1;
            i++;
        end
        if (!ok) timeout_fail("wait_done");
    endtask

    task automatic preset(input logic [CNT_W-1:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    task automatic set_len(input int i, input logic [CNT_W-1:0] v);
        len[i*CNT_W +: CNT_W] = v;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit              ok;
        int              c0, e0, prev, idx, runs;
        logic [CNT_W-1:0] c_start;

        rst = 1'b1;
        req = '0;
        len = '0;
        preset_en  = 1'b0;
        preset_val = '0;
        #6 rst = 1'b0;
        @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // 1: single job, len 5 from 0x10
        preset(8'h10);
        set_len(0, 8'd5);
        req = 4'b0001;
        c0  = cyc;
        e0  = enb_total;
        @(negedge clk);
        check("t1_gnt_next_cycle", 32'(gnt), 32'h1);
        wait_done(50, ok);
        check("t1_latency", 32'(cyc - c0), 32'd7);
        check("t1_done", 32'(done), 32'h1);
        check("t1_aborted", 32'(aborted), 32'd0);
        check("t1_count", 32'(count), 32'h15);
        check("t1_enb_cycles", 32'(enb_total - e0), 32'd5);
        req = '0;

        // 2: all four requesting with len 2, starting from pointer 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_len(i, 8'd2);
        req  = 4'b1111;
        prev = cyc;
        for (int j = 0; j < NREQ; j++) begin
            wait_done(50, ok);
            idx = 0;
            for (int b = 0; b < NREQ; b++) if (done[b]) idx = b;
            check("t2_order", 32'(idx), 32'(j));
            check("t2_spacing", 32'(cyc - prev), (j == 0) ? 32'd4 : 32'd5);
            prev = cyc;
            req[idx] = 1'b0;
        end

        // 3: wrap through all-ones
        preset(8'hFE);
        set_len(1, 8'd4);
        e0  = enb_total;
        req = 4'b0010;
        wait_done(50, ok);
        check("t3_done", 32'(done), 32'h2);
        check("t3_count", 32'(count), 32'h02);
        check("t3_enb_cycles", 32'(enb_total - e0), 32'd4);
        req = '0;

        // 4: zero-length job
        @(negedge clk);
        set_len(2, 8'd0);
        e0      = enb_total;
        c_start = count;
        req     = 4'b0100;
        c0      = cyc;
        wait_done(50, ok);
        check("t4_latency", 32'(cyc - c0), 32'd2);
        check("t4_done", 32'(done), 32'h4);
        check("t4_enb_cycles", 32'(enb_total - e0), 32'd0);
        check("t4_count", 32'(count), 32'(c_start));
        req = '0;

        // 5: abort after 3 enb cycles
        @(negedge clk);
        set_len(0, 8'd20);
        e0      = enb_total;
        c_start = count;
        req     = 4'b0001;
        runs    = 0;
        for (int i = 0; i < 60 && runs < 3; i++) begin
            @(negedge clk);
            if (cnt_enb) runs++;
        end
        if (runs < 3) timeout_fail("t5_run_wait");
        req = '0;
        c0  = cyc;
        wait_done(50, ok);
        check("t5_done_next_cycle", 32'(cyc - c0), 32'd1);
        check("t5_enb_low", 32'(cnt_enb), 32'd0);
        check("t5_done", 32'(done), 32'h1);
        check("t5_aborted", 32'(aborted), 32'd1);
        check("t5_count_delta", 32'(8'(count - c_start)), 32'd3);
        check("t5_enb_cycles", 32'(enb_total - e0), 32'd3);

        // 6: reset in the middle of a run; req3 waits behind it
        @(negedge clk);
        set_len(2, 8'd10);
        set_len(3, 8'd2);
        req  = 4'b1100;
        runs = 0;
        for (int i = 0; i < 60 && runs < 2; i++) begin
            @(negedge clk);
            if (cnt_enb) runs++;
        end
        if (runs < 2) timeout_fail("t6_run_wait");
        #2;
        rst = 1'b1;
        req = 4'b1000;
        #1;
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        check("t6_rst_enb", 32'(cnt_enb), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        c_start = count;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("t6_gnt_req3", 32'(gnt), 32'h8);
        check("t6_count_kept", 32'(count), 32'(c_start));
        wait_done(50, ok);
        check("t6_done", 32'(done), 32'h8);
        check("t6_aborted", 32'(aborted), 32'd0);
        req = '0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
